sram_like_arb: RTL

SRAM_LIKE_ARB -- requirements
Module: sram_like_arb

---
 rtl/sram_like_arb_pkg.sv | 22 ++
 rtl/sram_arb_idfifo.sv | 56 +++++
 rtl/sram_like_arb.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/sram_like_arb_pkg.sv
// Shared definitions for the SRAM-like request arbiter: size encodings, parameter defaults
// and a channel-index width helper.
package sram_like_arb_pkg;

  localparam int N_CH_DEF  = 2;
  localparam int DEPTH_DEF = 4;

  // Channel roles in the default two-master configuration.
  localparam int CH_INST = 0;
  localparam int CH_DATA = 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// In-order FIFO of granted channel indices, one entry per request accepted by the slave
// and not yet answered with data_ok.
module sram_arb_idfifo
  import sram_like_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int ID_W  = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ID_W-1:0]          push_id,
  output logic [ID_W-1:0]          head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/sram_like_arb.sv
// N-master to one-slave SRAM-like bus arbiter with address-phase lock and in-order data routing.
// Define SRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module sram_like_arb
  import sram_like_arb_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CH-1:0]        m_req,
  input  logic [N_CH-1:0]        m_wr,
  input  logic [2*N_CH-1:0]      m_size,
  input  logic [4*N_CH-1:0]      m_wstrb,
  input  logic [32*N_CH-1:0]     m_addr,
  input  logic [32*N_CH-1:0]     m_wdata,
  output logic [N_CH-1:0]        m_addr_ok,
  output logic [N_CH-1:0]        m_data_ok,
  output logic [31:0]            m_rdata,
  output logic                   s_req,
  output logic                   s_wr,
  output logic [1:0]             s_size,
  output logic [3:0]             s_wstrb,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  input  logic                   s_addr_ok,
  input  logic                   s_data_ok,
  input  logic [31:0]            s_rdata,
  output logic                   proto_err,
  output logic [$clog2(DEPTH):0] outstanding,
  output logic                   locked
);

  localparam int CH_W = ch_idx_w(N_CH);

  // Request handshake: a master holds m_req and its fields until m_addr_ok; the slave takes
  // the request in the cycle s_req && s_addr_ok, and answers each accepted request in order
  // with exactly one s_data_ok cycle.

  logic [CH_W-1:0] arb_idx;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W-1:0] lock_ch;
  logic            lock_q;
  logic [N_CH-1:0] gnt;
  logic            any_req;
  logic            lock_mismatch;
  logic            accept;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop_ok;
  logic [CH_W-1:0] fifo_head;

`ifdef SRAM_ARB_RR_EN
  logic [CH_W-1:0]   rr_ptr;
  logic [2*N_CH-1:0] req_dbl;

  // Rotating the doubled request vector puts the pointer's channel at bit 0.
  always_comb begin : rr_search
    logic          found;
    logic [CH_W:0] sum;
    found   = 1'b0;
    sum     = '0;
    arb_idx = '0;
    req_dbl = {m_req, m_req} >> rr_ptr;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && req_dbl[i]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (CH_W+1)'(i);
        if (sum >= (CH_W+1)'(N_CH)) arb_idx = CH_W'(sum - (CH_W+1)'(N_CH));
        else                        arb_idx = CH_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
`else
  always_comb begin
    arb_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m_req[i]) arb_idx = CH_W'(i);
    end
  end
`endif

  assign any_req       = |m_req;
  assign gnt_idx       = lock_q ? lock_ch : arb_idx;
  assign lock_mismatch = lock_q & ~m_req[lock_ch];
  assign s_req         = resetn & any_req & ~fifo_full & ~lock_mismatch;
  assign accept        = s_req & s_addr_ok;
  assign pop_ok        = resetn & s_data_ok & ~fifo_empty;
  assign m_rdata       = s_rdata;
  assign locked        = lock_q;

  always_comb begin
    gnt       = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    s_wr      = 1'b0;
    s_size    = '0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    for (int i = 0; i < N_CH; i++) begin
      gnt[i]       = (gnt_idx == CH_W'(i)) & (lock_q | any_req);
      m_addr_ok[i] = gnt[i] & accept;
      m_data_ok[i] = pop_ok & (fifo_head == CH_W'(i));
      if (gnt[i]) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_wstrb = m_wstrb[4*i +: 4];
        s_addr  = m_addr[32*i +: 32];
        s_wdata = m_wdata[32*i +: 32];
      end
    end
  end

  // Once offered, a request keeps its grant until the slave takes it, so the slave
  // never sees the address change under a stalled s_req.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q  <= 1'b0;
      lock_ch <= '0;
    end else if (accept) begin
      lock_q  <= 1'b0;
    end else if (s_req && !s_addr_ok) begin
      lock_q  <= 1'b1;
      lock_ch <= gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proto_err <= 1'b0;
    end else if (s_data_ok && fifo_empty) begin
      proto_err <= 1'b1;
    end
  end

  sram_arb_idfifo #(
    .DEPTH (DEPTH),
    .ID_W  (CH_W)
  ) u_idfifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (accept),
    .pop     (pop_ok),
    .push_id (gnt_idx),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

endmodule
